wb_trace_fifo: RTL and testbench
================================

Name: wb_trace_fifo

Overview:
- Downstream consumer of the CPU top's two debug trace ports: the main writeback trace and the uncached-load writeback trace.
- Filters out non-writing retirements and merges both streams into one ordered FIFO.
- Presents entries through a valid/ready stream to the simulator's golden-trace comparator.
- Records overflow so comparator mismatches caused by lost entries can be told apart from real core bugs.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 4
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
debug_wb_pc  in  32  main retire PC
debug_wb_rf_we  in  4  main byte write enables
debug_wb_rf_wnum  in  5  main dest register
debug_wb_rf_wdata  in  32  main write data
ld_debug_wb_pc  in  32  uncached-load retire PC
ld_debug_wb_rf_we  in  4  uncached-load byte enables
ld_debug_wb_rf_wnum  in  5  uncached-load dest register
ld_debug_wb_rf_wdata  in  32  uncached-load write data
stat_clr  in  1  clears overflow and drop_cnt
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_pc  out  32  head PC
out_wnum  out  5  head dest register
out_wdata  out  32  head data, disabled bytes zeroed
out_src  out  1  0 = main, 1 = uncached-load
count  out  CW  current occupancy
overflow  out  1  sticky: any entry dropped
drop_cnt  out  32  dropped-entry count, saturating

Behaviour:
- Hit per source: we != 0 and wnum != 0. Register r0 writes and we == 0 are ignored and never counted as drops.
- Stored data is wdata with each byte AND-ed by its we bit (e.g. we=4'b0011, wdata=0xAABBCCDD -> 0x0000CCDD).
- Push width is up to 2 per cycle.
  - Ordering: main at wr_ptr, ld at wr_ptr+1.
  - When only ld hits, it goes to wr_ptr.
- Free space is DEPTH - count, using the registered count before this cycle's pop. No same-cycle pop bypass.
- free >= hits: push all.
- free == 1 with two hits: push main, drop ld.
- free == 0: drop all hits.
- Any drop: overflow <= 1; drop_cnt += number dropped, saturating at 0xFFFFFFFF.
- Pop on out_valid && out_ready: rd_ptr++. Pop and push in the same cycle are both honoured; count <= count + pushes - pops.
- out_valid = (count != 0). out_* are read combinationally from storage at rd_ptr. Values are don't-care when out_valid = 0, but must be stable while out_valid && !out_ready.
- Pointers are log2(DEPTH) bits and wrap naturally.
- stat_clr has priority: overflow <= 0 and drop_cnt <= 0 that cycle, even if a drop occurs in the same cycle. FIFO contents are unaffected.
- Reset (async assert, sync release): rd_ptr = 0, wr_ptr = 0, count = 0, out_valid = 0, overflow = 0, drop_cnt = 0. Storage is not reset. Entries in flight at reset are discarded.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - 32-bit free-running cycle counter, reset to 0, increments every cycle and wraps.
  - Each pushed entry stores the counter value of its push cycle. Both entries pushed in the same cycle get the same stamp.
  - Extra output port out_ts, 32 bits.
- Undefined: no counter, no out_ts port, no timestamp storage.

Decomposition:
- Package wb_trace_pkg holds:
  - typedef trace_entry_t {pc, wnum, wdata, src[, ts]};
  - constants SRC_MAIN = 1'b0 and SRC_LD = 1'b1;
  - function mask_bytes(we, wdata).
- One sub-module, trace_filter: combinational hit detect plus byte masking, instantiated once per source.

Test Plan (DEPTH=4):
- Main we=4'hF wnum=3 wdata=0x12345678 pc=0xBFC00000, out_ready=1 -> next cycle out_valid=1, out_pc=0xBFC00000, out_wdata=0x12345678, out_src=0; count returns to 0.
- Both sources hit in one cycle (main pc=0x100, ld pc=0x104), out_ready=0 -> count=2; head pc=0x100 src=0; after one pop, head pc=0x104 src=1.
- Main wnum=0 we=4'hF, then we=0 wnum=5 -> no push, count=0, drop_cnt=0.
- out_ready=0, count=3, both hit -> main pushed, count=4, overflow=1, drop_cnt=1. Next cycle both hit -> drop_cnt=3.
- drop_cnt forced near 0xFFFFFFFF via repeated full-FIFO drops (or force) -> stays at 0xFFFFFFFF. stat_clr together with a drop -> drop_cnt=0, overflow=0.
- aresetn pulled low mid-stream with count=2 -> out_valid=0 and count=0 immediately (asynchronous), and both stay 0 after release until a new push.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared types and helpers for the writeback trace FIFO.
// Optional build macro: TRACE_TIMESTAMP_EN adds a 32-bit push timestamp to each entry.
package wb_trace_pkg;

  localparam logic SRC_MAIN = 1'b0;
  localparam logic SRC_LD   = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        src;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } trace_entry_t;

  // Zero every data byte whose write enable is clear.
  function automatic logic [31:0] mask_bytes(input logic [3:0] we, input logic [31:0] wdata);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = wdata[i*8 +: 8] & {8{we[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_trace_fifo_filter.sv
// Per-source retirement filter: decides whether a retirement wrote a real
// register and builds the masked trace entry. The timestamp field (when
// TRACE_TIMESTAMP_EN is defined) is left zero and filled in by the FIFO.
module trace_filter
  import wb_trace_pkg::*;
(
  input  logic         src,
  input  logic [31:0]  pc,
  input  logic [3:0]   we,
  input  logic [4:0]   wnum,
  input  logic [31:0]  wdata,
  output logic         hit,
  output trace_entry_t entry
);

  // r0 writes and zero byte-enables are not retirements worth tracing
  always_comb begin
    entry       = '0;
    entry.pc    = pc;
    entry.wnum  = wnum;
    entry.wdata = mask_bytes(we, wdata);
    entry.src   = src;
    hit         = (we != 4'd0) && (wnum != 5'd0);
  end

endmodule

// File: rtl/wb_trace_fifo.sv
// Merges the main and uncached-load writeback traces into one ordered FIFO
// with drop accounting. Main is always ordered ahead of ld in the same cycle.
// Optional build macro: TRACE_TIMESTAMP_EN adds a cycle counter and out_ts.
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [31:0]   debug_wb_pc,
  input  logic [3:0]    debug_wb_rf_we,
  input  logic [4:0]    debug_wb_rf_wnum,
  input  logic [31:0]   debug_wb_rf_wdata,
  input  logic [31:0]   ld_debug_wb_pc,
  input  logic [3:0]    ld_debug_wb_rf_we,
  input  logic [4:0]    ld_debug_wb_rf_wnum,
  input  logic [31:0]   ld_debug_wb_rf_wdata,
  input  logic          stat_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [4:0]    out_wnum,
  output logic [31:0]   out_wdata,
  output logic          out_src,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [31:0]   drop_cnt
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]   out_ts
`endif
);

  localparam int PW = $clog2(DEPTH);

  trace_entry_t  ent_m, ent_l, head;
  logic          hit_m, hit_l;
  trace_entry_t  mem_q [DEPTH];
  trace_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, free;
  logic          overflow_q, overflow_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;
  logic          push_m, push_l, pop;
  logic [1:0]    n_drop;
  logic [32:0]   drop_sum;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]   ts_q, ts_d;
`endif

  trace_filter u_filt_main (
    .src(SRC_MAIN), .pc(debug_wb_pc), .we(debug_wb_rf_we), .wnum(debug_wb_rf_wnum),
    .wdata(debug_wb_rf_wdata), .hit(hit_m), .entry(ent_m)
  );

  trace_filter u_filt_ld (
    .src(SRC_LD), .pc(ld_debug_wb_pc), .we(ld_debug_wb_rf_we), .wnum(ld_debug_wb_rf_wnum),
    .wdata(ld_debug_wb_rf_wdata), .hit(hit_l), .entry(ent_l)
  );

  // Push/pop decision, storage writes and drop accounting; free space ignores this cycle's pop
  always_comb begin
    trace_entry_t e_m, e_l;
    e_m        = ent_m;
    e_l        = ent_l;
`ifdef TRACE_TIMESTAMP_EN
    e_m.ts     = ts_q;
    e_l.ts     = ts_q;
    ts_d       = ts_q + 32'd1;
`endif
    mem_d      = mem_q;
    free       = CW'(DEPTH) - count_q;
    push_m     = hit_m && (free != '0);
    push_l     = hit_l && (push_m ? (free >= CW'(2)) : (free != '0));
    if (push_m) mem_d[wr_ptr_q] = e_m;
    if (push_l) mem_d[wr_ptr_q + PW'(push_m)] = e_l;
    pop        = (count_q != '0) && out_ready;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push_m) + PW'(push_l);
    count_d    = count_q + CW'(push_m) + CW'(push_l) - CW'(pop);
    n_drop     = 2'(hit_m && !push_m) + 2'(hit_l && !push_l);
    drop_sum   = {1'b0, drop_cnt_q} + {31'd0, n_drop};
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (stat_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 32'd0;
    end else if (n_drop != 2'd0) begin
      overflow_d = 1'b1;
      drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end

  // Control state; async reset discards anything in flight
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 32'd0;
`ifdef TRACE_TIMESTAMP_EN
      ts_q       <= 32'd0;
`endif
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef TRACE_TIMESTAMP_EN
      ts_q       <= ts_d;
`endif
    end
  end

  // Entry storage is deliberately not reset
  always_ff @(posedge aclk) begin
    mem_q <= mem_d;
  end

  // Head entry is presented straight from storage
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = (count_q != '0);
    out_pc    = head.pc;
    out_wnum  = head.wnum;
    out_wdata = head.wdata;
    out_src   = head.src;
`ifdef TRACE_TIMESTAMP_EN
    out_ts    = head.ts;
`endif
    count     = count_q;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo (DEPTH=4). A reference model at the
// clock edge appends expected entries; a monitor on the falling edge compares
// the head and status outputs and retires entries on handshakes.
module tb_wb_trace_fifo;

  localparam int DEPTH = 4;
  localparam int TB_CW = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        src;
    logic [31:0] ts;
  } exp_t;

  logic             aclk, aresetn;
  logic [31:0]      m_pc, m_wdata, l_pc, l_wdata;
  logic [3:0]       m_we, l_we;
  logic [4:0]       m_wnum, l_wnum;
  logic             stat_clr, out_ready;
  logic             out_valid, out_src, overflow;
  logic [31:0]      out_pc, out_wdata, drop_cnt;
  logic [4:0]       out_wnum;
  logic [TB_CW-1:0] count;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]      out_ts;
`endif

  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  int          mdl_count = 0;
  logic        mdl_ovf = 1'b0;
  logic [31:0] mdl_drop = 32'd0;
  logic [31:0] mdl_ts = 32'd0;

  wb_trace_fifo #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .debug_wb_pc(m_pc), .debug_wb_rf_we(m_we), .debug_wb_rf_wnum(m_wnum), .debug_wb_rf_wdata(m_wdata),
    .ld_debug_wb_pc(l_pc), .ld_debug_wb_rf_we(l_we), .ld_debug_wb_rf_wnum(l_wnum), .ld_debug_wb_rf_wdata(l_wdata),
    .stat_clr(stat_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_wnum(out_wnum), .out_wdata(out_wdata), .out_src(out_src),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef TRACE_TIMESTAMP_EN
    , .out_ts(out_ts)
`endif
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] keep_enabled_bytes(input logic [3:0] we, input logic [31:0] d);
    logic [31:0] r = 32'd0;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Reference model: admits up to the free space, main first, at each rising edge
  always @(posedge aclk) begin : model
    int   nh, np, fr, drops, pops;
    bit   hm, hl, pm, pl;
    exp_t e;
    longint s;
    if (aresetn) begin
      hm = (m_we != 0) && (m_wnum != 0);
      hl = (l_we != 0) && (l_wnum != 0);
      nh = int'(hm) + int'(hl);
      fr = DEPTH - mdl_count;
      np = (nh < fr) ? nh : fr;
      pm = hm && (np > 0);
      pl = hl && ((np - int'(pm)) > 0);
      if (pm) begin
        e = '{pc: m_pc, wnum: m_wnum, wdata: keep_enabled_bytes(m_we, m_wdata), src: 1'b0, ts: mdl_ts};
        exp_q.push_back(e);
      end
      if (pl) begin
        e = '{pc: l_pc, wnum: l_wnum, wdata: keep_enabled_bytes(l_we, l_wdata), src: 1'b1, ts: mdl_ts};
        exp_q.push_back(e);
      end
      pops = (mdl_count > 0 && out_ready) ? 1 : 0;
      mdl_count = mdl_count + np - pops;
      drops = nh - np;
      if (stat_clr) begin
        mdl_ovf = 1'b0;
        mdl_drop = 32'd0;
      end else if (drops > 0) begin
        mdl_ovf = 1'b1;
        s = longint'(mdl_drop) + longint'(drops);
        mdl_drop = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
      end
      mdl_ts = mdl_ts + 32'd1;
    end
  end

  // Monitor: compare status every cycle, head whenever valid, retire on handshake
  always @(negedge aclk) begin
    chk("count", 32'(count), 32'(mdl_count));
    chk("out_valid", 32'(out_valid), 32'(mdl_count != 0));
    chk("overflow", 32'(overflow), 32'(mdl_ovf));
    chk("drop_cnt", drop_cnt, mdl_drop);
    if (mdl_count != 0 && exp_q.size() > 0) begin
      chk("head_pc", out_pc, exp_q[0].pc);
      chk("head_wnum", 32'(out_wnum), 32'(exp_q[0].wnum));
      chk("head_wdata", out_wdata, exp_q[0].wdata);
      chk("head_src", 32'(out_src), 32'(exp_q[0].src));
`ifdef TRACE_TIMESTAMP_EN
      chk("head_ts", out_ts, exp_q[0].ts);
`endif
    end
    if (aresetn && mdl_count != 0 && out_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else chk("scoreboard_underrun", 32'(exp_q.size()), 32'd1);
    end
  end

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic idle();
    m_we = 4'd0; m_wnum = 5'd0; m_pc = 32'd0; m_wdata = 32'd0;
    l_we = 4'd0; l_wnum = 5'd0; l_pc = 32'd0; l_wdata = 32'd0;
    stat_clr = 1'b0;
  endtask

  task automatic set_main(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn, input logic [31:0] d);
    m_pc = pc; m_we = we; m_wnum = wn; m_wdata = d;
  endtask

  task automatic set_ld(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn, input logic [31:0] d);
    l_pc = pc; l_we = we; l_wnum = wn; l_wdata = d;
  endtask

  task automatic clear_model();
    exp_q.delete();
    mdl_count = 0;
    mdl_ovf = 1'b0;
    mdl_drop = 32'd0;
    mdl_ts = 32'd0;
  endtask

  initial begin
    aresetn = 1'b0; out_ready = 1'b0;
    idle();
    repeat (3) step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_drop", drop_cnt, 32'd0);
    aresetn = 1'b1;
    step();

    // single main push, consumer always ready
    out_ready = 1'b1;
    set_main(32'hBFC0_0000, 4'hF, 5'd3, 32'h1234_5678);
    step(); idle();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_pc", out_pc, 32'hBFC0_0000);
    chk("single_wdata", out_wdata, 32'h1234_5678);
    chk("single_src", 32'(out_src), 32'd0);
    step();
    chk("single_drained", 32'(count), 32'd0);

    // both sources in one cycle: main ahead of ld
    out_ready = 1'b0;
    set_main(32'h100, 4'hF, 5'd1, 32'h1111_1111);
    set_ld(32'h104, 4'hF, 5'd2, 32'h2222_2222);
    step(); idle();
    chk("both_count", 32'(count), 32'd2);
    chk("both_head_pc", out_pc, 32'h100);
    chk("both_head_src", 32'(out_src), 32'd0);
    out_ready = 1'b1;
    step(); out_ready = 1'b0;
    chk("both_second_pc", out_pc, 32'h104);
    chk("both_second_src", 32'(out_src), 32'd1);
    out_ready = 1'b1;
    step(); out_ready = 1'b0;

    // non-writing retirements are ignored
    set_main(32'h200, 4'hF, 5'd0, 32'hDEAD_BEEF);
    step();
    set_main(32'h204, 4'h0, 5'd5, 32'hDEAD_BEEF);
    step(); idle();
    chk("filter_count", 32'(count), 32'd0);
    chk("filter_drop", drop_cnt, 32'd0);

    // byte masking
    set_main(32'h300, 4'b0011, 5'd1, 32'hAABB_CCDD);
    step(); idle();
    chk("mask_wdata", out_wdata, 32'h0000_CCDD);
    out_ready = 1'b1;
    step(); out_ready = 1'b0;

    // fill to 3, then two hits with one free slot, then two with none
    for (int i = 0; i < 3; i++) begin
      set_main(32'h400 + 32'(i * 4), 4'hF, 5'd7, 32'(i));
      step();
    end
    set_main(32'h410, 4'hF, 5'd8, 32'hA);
    set_ld(32'h414, 4'hF, 5'd9, 32'hB);
    step();
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop1", drop_cnt, 32'd1);
    step();
    chk("ovf_drop3", drop_cnt, 32'd3);

    // saturation near the top of the counter
    force dut.drop_cnt_q = 32'hFFFF_FFFE;
    mdl_drop = 32'hFFFF_FFFE;
    release dut.drop_cnt_q;
    step();
    chk("sat_drop", drop_cnt, 32'hFFFF_FFFF);
    step();
    chk("sat_hold", drop_cnt, 32'hFFFF_FFFF);
    stat_clr = 1'b1;
    step(); stat_clr = 1'b0; idle();
    chk("clr_drop", drop_cnt, 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_keeps_fifo", 32'(count), 32'd4);

    out_ready = 1'b1;
    repeat (DEPTH + 1) step();
    out_ready = 1'b0;

    // asynchronous reset with entries in flight
    set_main(32'h500, 4'hF, 5'd4, 32'h5);
    set_ld(32'h504, 4'hF, 5'd6, 32'h6);
    step();
    chk("pre_rst_count", 32'(count), 32'd2);
    aresetn = 1'b0;
    #1;
    clear_model();
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    step(); step();
    idle();
    aresetn = 1'b1;
    step();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    // randomized traffic with varying consumer throughput
    for (int c = 0; c < 600; c++) begin
      m_we    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      m_wnum  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      m_pc    = $urandom; m_wdata = $urandom;
      l_we    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      l_wnum  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      l_pc    = $urandom; l_wdata = $urandom;
      stat_clr  = ($urandom_range(0, 40) == 0);
      out_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end

    idle();
    out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("final_count", 32'(count), 32'd0);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
